// File: rtl/led_scan_driver.sv
// 8x8 red/green LED matrix line scanner: snapshots both frames once per frame, then lights one line at a time.
// Optional inter-line blanking is compiled in when the SCAN_BLANK_EN macro is defined.
module led_scan_driver #(
    parameter int DWELL = 16,
    parameter int BLANK = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0][7:0] red_array,
    input  logic [7:0][7:0] green_array,
    output logic [7:0]      line_n,
    output logic [7:0]      red_col,
    output logic [7:0]      green_col,
    output logic            frame_start
);

    localparam int DW = $clog2(DWELL + 1);

    if (DWELL < 1 || DWELL > 65535 || BLANK < 1 || BLANK > 65535) begin : g_bad_params
        $error("led_scan_driver: DWELL and BLANK must be in 1..65535");
    end

`ifdef SCAN_BLANK_EN
    localparam int BW = $clog2(BLANK + 1);
    typedef enum logic [1:0] {S_LOAD, S_SHOW, S_BLANK} state_t;
    logic [BW-1:0] blank_reg, blank_next;
`else
    typedef enum logic {S_LOAD, S_SHOW} state_t;
`endif

    state_t          state_reg, state_next;
    logic [2:0]      line_reg, line_next;
    logic [DW-1:0]   dwell_reg, dwell_next;
    logic            load_snap;
    logic [7:0][7:0] red_snap_reg, green_snap_reg;

    logic [7:0]      line_n_reg, line_n_next;
    logic [7:0]      red_col_reg, red_col_next;
    logic [7:0]      green_col_reg, green_col_next;
    logic            frame_start_reg, frame_start_next;

    always_comb begin
        state_next = state_reg;
        line_next  = line_reg;
        dwell_next = dwell_reg;
        load_snap  = 1'b0;
`ifdef SCAN_BLANK_EN
        blank_next = blank_reg;
`endif
        case (state_reg)
            S_LOAD: begin
                load_snap  = 1'b1;
                line_next  = 3'd0;
                dwell_next = '0;
                state_next = S_SHOW;
            end
            S_SHOW: begin
                if (dwell_reg == DW'(DWELL - 1)) begin
                    dwell_next = '0;
`ifdef SCAN_BLANK_EN
                    blank_next = '0;
                    state_next = S_BLANK;
`else
                    if (line_reg == 3'd7) begin
                        state_next = S_LOAD;
                    end else begin
                        line_next = line_reg + 3'd1;
                    end
`endif
                end else begin
                    dwell_next = dwell_reg + DW'(1);
                end
            end
`ifdef SCAN_BLANK_EN
            S_BLANK: begin
                if (blank_reg == BW'(BLANK - 1)) begin
                    blank_next = '0;
                    if (line_reg == 3'd7) begin
                        state_next = S_LOAD;
                    end else begin
                        line_next  = line_reg + 3'd1;
                        state_next = S_SHOW;
                    end
                end else begin
                    blank_next = blank_reg + BW'(1);
                end
            end
`endif
            default: state_next = S_LOAD;
        endcase
    end

    // Outputs are registered from the current state, so the pins trail the FSM by one cycle.
    always_comb begin
        line_n_next      = 8'hFF;
        red_col_next     = 8'h00;
        green_col_next   = 8'h00;
        frame_start_next = (state_reg == S_LOAD);
        if (state_reg == S_SHOW) begin
            line_n_next    = ~(8'h01 << line_reg);
            red_col_next   = red_snap_reg[line_reg];
            green_col_next = green_snap_reg[line_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_LOAD;
            line_reg        <= 3'd0;
            dwell_reg       <= '0;
            line_n_reg      <= 8'hFF;
            red_col_reg     <= 8'h00;
            green_col_reg   <= 8'h00;
            frame_start_reg <= 1'b0;
`ifdef SCAN_BLANK_EN
            blank_reg       <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            line_reg        <= line_next;
            dwell_reg       <= dwell_next;
            line_n_reg      <= line_n_next;
            red_col_reg     <= red_col_next;
            green_col_reg   <= green_col_next;
            frame_start_reg <= frame_start_next;
`ifdef SCAN_BLANK_EN
            blank_reg       <= blank_next;
`endif
        end
    end

    // Frame snapshot: inputs only matter on the LOAD edge, which keeps a frame tear-free.
    for (genvar gi = 0; gi < 8; gi++) begin : g_snap
        always_ff @(posedge clk) begin
            if (reset) begin
                red_snap_reg[gi]   <= 8'h00;
                green_snap_reg[gi] <= 8'h00;
            end else if (load_snap) begin
                red_snap_reg[gi]   <= red_array[gi];
                green_snap_reg[gi] <= green_array[gi];
            end
        end
    end

    assign line_n      = line_n_reg;
    assign red_col     = red_col_reg;
    assign green_col   = green_col_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_led_scan_driver.sv
// Self-checking bench for led_scan_driver: frame-position model checked every cycle plus directed literal checks.
module tb_led_scan_driver;

    localparam int DWELL   = 16;
    localparam int BLANK_C = 2;
`ifdef SCAN_BLANK_EN
    localparam int SLOT = DWELL + BLANK_C;
`else
    localparam int SLOT = DWELL;
`endif
    localparam int PERIOD = 1 + 8 * SLOT;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0][7:0] red_array;
    logic [7:0][7:0] green_array;
    logic [7:0]      line_n, red_col, green_col;
    logic            frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_scan_driver #(.DWELL(DWELL), .BLANK(BLANK_C)) dut (
        .clk         (clk),
        .reset       (reset),
        .red_array   (red_array),
        .green_array (green_array),
        .line_n      (line_n),
        .red_col     (red_col),
        .green_col   (green_col),
        .frame_start (frame_start)
    );

    // Model: position p within the visible frame (-1 = reset output cycle, 0 = frame_start cycle).
    int              p_model = -2;
    logic [7:0][7:0] red_m, green_m;

    always @(posedge clk) begin
        if (reset) begin
            p_model <= -1;
        end else if (p_model == -1 || p_model == PERIOD - 1) begin
            p_model <= 0;
            red_m   <= red_array;
            green_m <= green_array;
        end else if (p_model >= 0) begin
            p_model <= p_model + 1;
        end
    end

    logic [7:0] exp_ln, exp_r, exp_g, one_hot;
    logic       exp_fs;
    int         k_line, k_off;

    always @(negedge clk) begin
        if (p_model >= -1) begin
            exp_ln = 8'hFF;
            exp_r  = 8'h00;
            exp_g  = 8'h00;
            exp_fs = (p_model == 0);
            if (p_model >= 1) begin
                k_line = (p_model - 1) / SLOT;
                k_off  = (p_model - 1) % SLOT;
                if (k_off < DWELL) begin
                    one_hot = 8'h01 << k_line;
                    exp_ln  = ~one_hot;
                    exp_r   = red_m[k_line];
                    exp_g   = green_m[k_line];
                end
            end
            checks++;
            if (line_n !== exp_ln || red_col !== exp_r || green_col !== exp_g || frame_start !== exp_fs) begin
                errors++;
                $display("[%0t] FAIL model p=%0d: got ln=%h r=%h g=%h fs=%b, need ln=%h r=%h g=%h fs=%b",
                         $time, p_model, line_n, red_col, green_col, frame_start,
                         exp_ln, exp_r, exp_g, exp_fs);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("[%0t] FAIL %s: got %h, need %h", $time, name, got, need);
        end else begin
            $display("[%0t] ok %s = %h", $time, name, got);
        end
    endtask

    task automatic wait_line(input int idx);
        logic [7:0] one;
        int n;
        one = 8'h01 << idx;
        n = 0;
        @(negedge clk);
        while (line_n !== ~one && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("[%0t] FAIL wait_line%0d: got timeout, need line lit", $time, idx);
        end
    endtask

    task automatic wait_fs(output int steps);
        steps = 0;
        do begin
            @(negedge clk);
            steps++;
        end while (frame_start !== 1'b1 && steps < 1000);
        if (steps >= 1000) begin
            checks++;
            errors++;
            $display("[%0t] FAIL wait_fs: got timeout, need frame_start", $time);
        end
    endtask

    initial begin
        int steps;
        for (int s = 0; s < 8; s++) begin
            red_array[s]   = 8'h01 << s;
            green_array[s] = 8'h00;
        end

        // Reset for three edges, then release.
        repeat (3) @(negedge clk);
        check("reset_line_n", 32'(line_n), 32'hFF);
        check("reset_cols", {16'h0, red_col, green_col}, 32'h0);
        check("reset_fs", 32'(frame_start), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("first_fs", 32'(frame_start), 32'h1);
        check("first_fs_line_n", 32'(line_n), 32'hFF);
        @(negedge clk);
        check("line0_line_n", 32'(line_n), 32'hFE);
        check("line0_red", 32'(red_col), 32'h01);

        // Frame period and the slot after line 0.
        wait_fs(steps);
        wait_fs(steps);
        check("frame_period", 32'(steps), 32'(PERIOD));
        repeat (DWELL + 1) @(negedge clk);
`ifdef SCAN_BLANK_EN
        check("after_line0", 32'(line_n), 32'hFF);
`else
        check("after_line0", 32'(line_n), 32'hFD);
`endif
        wait_line(3);
        check("line3_red", 32'(red_col), 32'h08);

        // Tear-free: green line 5 changes while line 2 is lit.
        wait_line(2);
        green_array[5] = 8'hFF;
        wait_line(5);
        check("tear_free_same_frame", 32'(green_col), 32'h00);
        wait_fs(steps);
        wait_line(5);
        check("tear_free_next_frame", 32'(green_col), 32'hFF);

        // Overlapping red/green pixel on line 0.
        red_array[0]   = 8'h80;
        green_array[0] = 8'h80;
        wait_fs(steps);
        wait_line(0);
        check("overlap_red", 32'(red_col), 32'h80);
        check("overlap_green", 32'(green_col), 32'h80);

        // Arbitrary array churn; the per-cycle model covers it.
        repeat (300) begin
            @(negedge clk);
            red_array[$urandom_range(7)]   = 8'($urandom);
            green_array[$urandom_range(7)] = 8'($urandom);
        end

        // One-cycle reset while line 4 is lit.
        wait_line(4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_line_n", 32'(line_n), 32'hFF);
        check("midreset_cols", {16'h0, red_col, green_col}, 32'h0);
        check("midreset_fs", 32'(frame_start), 32'h0);
        @(negedge clk);
        check("midreset_load_fs", 32'(frame_start), 32'h1);
        @(negedge clk);
        check("midreset_restart_line", 32'(line_n), 32'hFE);
        check("midreset_restart_red", 32'(red_col), 32'(red_array[0]));

        wait_fs(steps);
        check("midreset_period", 32'(steps), 32'(PERIOD - 1));
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
